sar_ctrl: RTL
=============

SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter RES, default 10: conversion resolution in bits; legal range 4..16.
REQ-002 Parameter SAMPLE_CYC, default 2: track (sample) phase length in clk cycles; legal range 1..255.
REQ-003 Parameter SETTLE_CYC, default 1: DAC/comparator settle cycles per bit; legal range 0..15.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  conversion request, sampled only in IDLE.
REQ-007 comp_out  input  1  comparator decision: 1 = Vin >= DAC, keep trial bit.
REQ-008 sample  output  1  track/hold control; high during SAMPLE phase only.
REQ-009 dac_code  output  RES  trial code driving the capacitive DAC.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 data_out  output  RES  last completed conversion result, held until next completion.
REQ-012 eoc  output  1  one-cycle pulse, high in DONE.
REQ-013 ovr  output  1  saturation flag, qualified by eoc (see Configuration).

Function
REQ-014 States: IDLE, SAMPLE, SET, SETTLE, DECIDE, DONE; encoding from the shared package.
REQ-015 IDLE: start=1 -> SAMPLE, dac_code cleared, bit index = RES-1; start=0 -> stay.
REQ-016 SAMPLE: sample=1 for exactly SAMPLE_CYC cycles, then -> SET.
REQ-017 SET: dac_code[idx] set to 1 (other bits unchanged), -> SETTLE, or -> DECIDE if SETTLE_CYC=0.
REQ-018 SETTLE: held exactly SETTLE_CYC cycles, then -> DECIDE.
REQ-019 DECIDE: comp_out=0 clears dac_code[idx]; idx>0 -> decrement idx, -> SET; idx=0 -> DONE.
REQ-020 DONE: data_out <= final code, eoc=1 for this single cycle, -> IDLE.
REQ-021 Latency: edges from start-sampling edge to DONE entry = SAMPLE_CYC + RES*(SETTLE_CYC+2); defaults give 32.
REQ-022 start while busy is ignored; no queuing; start held high in IDLE after DONE begins a new conversion immediately.
REQ-023 comp_out is read only in DECIDE; its value in all other states has no effect.
REQ-024 Bit index is unsigned and never wraps; the LSB decision terminates the conversion.
REQ-025 data_out changes only on DONE entry; busy, sample and eoc are registered outputs.

Reset
REQ-026 rst=1 at any clock edge, including mid-conversion: state=IDLE, dac_code=0, data_out=0, busy=0, sample=0, eoc=0, ovr=0, timers cleared.
REQ-027 An interrupted conversion produces no eoc and leaves data_out at 0.

Configuration
REQ-028 Macro SAR_CTRL_OVR_FLAG_EN defined: ovr is registered on DONE entry, high when the final code is all-ones or all-zeros, and otherwise low; ovr holds its value until the next DONE.
REQ-029 Macro SAR_CTRL_OVR_FLAG_EN undefined: ovr is tied to 0 and no flag logic is synthesised; the port is still present.

Structure
REQ-030 Package sar_pkg holds the state typedef/encoding and the parameter legal-range limits.
REQ-031 One sub-module, sar_timer: loadable down-counter with a zero flag, shared by the SAMPLE and SETTLE phases.

Verification
REQ-032 Defaults, comp model with Vin code 0x2A5, one start pulse -> eoc exactly 32 cycles after the start edge, data_out=0x2A5, busy high for 33 cycles.
REQ-033 comp_out stuck 1 -> data_out=0x3FF, ovr=1 with macro defined, ovr=0 with macro undefined; comp_out stuck 0 -> data_out=0x000, with the same ovr rule.
REQ-034 start pulsed at cycles 5 and 20 of a conversion -> ignored; exactly one eoc is produced.
REQ-035 rst asserted at cycle 15 of a conversion -> next cycle all outputs 0, state IDLE, no eoc; a new start then yields a correct result.
REQ-036 RES=12, SAMPLE_CYC=1, SETTLE_CYC=0, Vin code 0x801 -> eoc after 25 cycles, data_out=0x801.
REQ-037 start held high continuously -> back-to-back conversions with one IDLE cycle between DONE and SAMPLE; eoc period = 34 cycles at default parameters.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg -- shared definitions for the SAR conversion controller.
//
// Contents:
//   sar_state_t    controller state encoding (IDLE, SAMPLE, SET, SETTLE, DECIDE, DONE)
//   *_MIN/*_MAX    legal ranges of the sar_ctrl parameters
//   TIMER_W        width of the shared phase timer (covers SAMPLE_CYC up to 255)
//   params_legal   helper that checks a parameter set against the ranges
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SET    = 3'd2,
    SETTLE = 3'd3,
    DECIDE = 3'd4,
    DONE   = 3'd5
  } sar_state_t;

  localparam int RES_MIN        = 4;
  localparam int RES_MAX        = 16;
  localparam int SAMPLE_CYC_MIN = 1;
  localparam int SAMPLE_CYC_MAX = 255;
  localparam int SETTLE_CYC_MIN = 0;
  localparam int SETTLE_CYC_MAX = 15;

  localparam int TIMER_W = 8;

  function automatic bit params_legal(input int res, input int sample_cyc,
                                      input int settle_cyc);
    return (res >= RES_MIN) && (res <= RES_MAX) &&
           (sample_cyc >= SAMPLE_CYC_MIN) && (sample_cyc <= SAMPLE_CYC_MAX) &&
           (settle_cyc >= SETTLE_CYC_MIN) && (settle_cyc <= SETTLE_CYC_MAX);
  endfunction

endpackage

// File: rtl/sar_timer.sv
// sar_timer -- loadable down-counter with a zero flag, shared by the SAMPLE
// and SETTLE phases of the SAR controller.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val into the counter (has priority over dec)
//   dec       decrement by one; the count stops at zero
//   load_val  value to load
//   zero      high while the count is zero
module sar_timer
  import sar_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl -- successive-approximation ADC controller.
//
// A conversion tracks the input for SAMPLE_CYC cycles, then resolves one bit
// per SET / SETTLE / DECIDE pass from MSB to LSB and publishes the code in DONE.
//
// Parameters: RES (4..16), SAMPLE_CYC (1..255), SETTLE_CYC (0..15)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     conversion request, only looked at in IDLE
//   comp_out  comparator decision (1 = Vin >= DAC, keep the trial bit)
//   sample    track/hold control, high during SAMPLE
//   dac_code  trial code for the capacitive DAC
//   busy      high in every state except IDLE
//   data_out  last completed result, updated on DONE entry only
//   eoc       one-cycle end-of-conversion pulse (high in DONE)
//   ovr       saturation flag, qualified by eoc
//
// Optional feature: define SAR_CTRL_OVR_FLAG_EN to flag all-ones / all-zeros
// results on ovr; otherwise ovr is tied low.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int RES        = 10,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           comp_out,
  output logic           sample,
  output logic [RES-1:0] dac_code,
  output logic           busy,
  output logic [RES-1:0] data_out,
  output logic           eoc,
  output logic           ovr
);

  localparam int IDX_W = $clog2(RES);
  localparam logic [IDX_W-1:0]   IDX_MSB     = IDX_W'(RES - 1);
  localparam logic [TIMER_W-1:0] SAMPLE_LOAD = TIMER_W'(SAMPLE_CYC - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  if (!params_legal(RES, SAMPLE_CYC, SETTLE_CYC)) begin : g_illegal_params
    $error("sar_ctrl: RES, SAMPLE_CYC or SETTLE_CYC outside the legal range");
  end

  sar_state_t           state, state_next;
  logic [RES-1:0]       dac_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic                 timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0]   timer_load_val;

  // The timer is loaded with (length - 1) on phase entry, so the phase lasts
  // until the count reaches zero: exactly SAMPLE_CYC / SETTLE_CYC cycles.
  sar_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  // State register plus the registered datapath. busy/sample/eoc are decoded
  // from the next state so they are glitch-free flops aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dac_code <= '0;
      idx      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      sample   <= 1'b0;
      eoc      <= 1'b0;
    end else begin
      state    <= state_next;
      dac_code <= dac_next;
      idx      <= idx_next;
      busy     <= (state_next != IDLE);
      sample   <= (state_next == SAMPLE);
      eoc      <= (state_next == DONE);
      if (state_next == DONE) begin
        data_out <= dac_next;
      end
    end
  end

  // Next-state, trial-code and timer control. The final DECIDE updates
  // dac_next, which is what gets captured into data_out on DONE entry.
  always_comb begin
    state_next     = state;
    dac_next       = dac_code;
    idx_next       = idx;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;
    timer_load_val = SAMPLE_LOAD;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SAMPLE;
          dac_next   = '0;
          idx_next   = IDX_MSB;
          timer_load = 1'b1;
        end
      end
      SAMPLE: begin
        if (timer_zero) state_next = SET;
        else            timer_dec  = 1'b1;
      end
      SET: begin
        dac_next[idx] = 1'b1;
        if (SETTLE_CYC == 0) begin
          state_next = DECIDE;
        end else begin
          state_next     = SETTLE;
          timer_load     = 1'b1;
          timer_load_val = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (timer_zero) state_next = DECIDE;
        else            timer_dec  = 1'b1;
      end
      DECIDE: begin
        if (!comp_out) dac_next[idx] = 1'b0;
        if (idx != '0) begin
          idx_next   = idx - 1'b1;
          state_next = SET;
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SAR_CTRL_OVR_FLAG_EN
  // Saturation flag: captured alongside data_out and held until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (state_next == DONE) begin
      ovr <= (dac_next == '1) || (dac_next == '0);
    end
  end
`else
  assign ovr = 1'b0;
`endif

endmodule
